rr_mux_arbiter: RTL and testbench

- Round-robin arbiter that shares one N-input, WIDTH-bit selection datapath among N requesters.
- Selects one requester per cycle, captures its data into a single output register, and presents it downstream with a valid/ready handshake.
- Used in the IFQ front end to merge fetch sources (redirect, sequential, replay) into one queue write port.

---
 rtl/ifq_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_mux_arbiter.sv | 61 ++++++
 tb/tb_rr_mux_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ifq_arb_pkg.sv
// rtl/ifq_arb_pkg.sv - shared types and index helpers for the IFQ round-robin arbiter
package ifq_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Fold an index in [0, 2n) back into [0, n); works for any n, power of two or not.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

  function automatic int next_ptr(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: rotate, fixed-priority encode, un-rotate
module rr_pick
  import ifq_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  logic [N-1:0] rot;
  logic         found;
  int           off;

  always_comb begin
    rot = '0;
    // Constant-index compares keep the rotate free of variable part-selects.
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (wrap_idx(i + int'(ptr), N) == k) rot[i] = req[k];
      end
    end

    found = 1'b0;
    off   = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end

    winner = '0;
    for (int k = 0; k < N; k++) begin
      if (wrap_idx(off + int'(ptr), N) == k) winner = IW'(k);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin N:1 arbiter with a single registered valid/ready output stage
module rr_mux_arbiter
  import ifq_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int IW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     REQ,
  input  logic [WIDTH-1:0] X [N-1:0],
  output logic [N-1:0]     ACK,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [IW-1:0]    OUT_SRC
);

  arb_state_e    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic          any_req;
  logic          load;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (REQ),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // A FULL register may be refilled in the same cycle it drains.
  assign load = (state == EMPTY || OUT_READY) && any_req;

  always_comb begin
    ACK = '0;
    for (int i = 0; i < N; i++) begin
      ACK[i] = !rst && load && (winner == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      OUT_DATA <= '0;
      OUT_SRC  <= '0;
    end else if (load) begin
      state    <= FULL;
      OUT_DATA <= X[winner];
      OUT_SRC  <= winner;
      ptr      <= IW'(next_ptr(int'(winner), N));
    end else if (state == FULL && OUT_READY) begin
      state <= EMPTY;
    end
  end

  assign OUT_VALID = (state == FULL);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter (N=4 and N=3 instances)
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  a_req;
  logic [31:0] a_x [3:0];
  logic [3:0]  a_ack;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic [1:0]  a_src;

  logic [2:0]  b_req;
  logic [15:0] b_x [2:0];
  logic [2:0]  b_ack;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_data;
  logic [1:0]  b_src;

  rr_mux_arbiter #(.WIDTH(32), .N(4)) dut_a (
    .clk(clk), .rst(rst), .REQ(a_req), .X(a_x), .ACK(a_ack),
    .OUT_VALID(a_valid), .OUT_READY(a_ready), .OUT_DATA(a_data), .OUT_SRC(a_src)
  );

  rr_mux_arbiter #(.WIDTH(16), .N(3)) dut_b (
    .clk(clk), .rst(rst), .REQ(b_req), .X(b_x), .ACK(b_ack),
    .OUT_VALID(b_valid), .OUT_READY(b_ready), .OUT_DATA(b_data), .OUT_SRC(b_src)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  src;
  } item_t;

  item_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted output beat must match the oldest expected load.
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", 64'(a_src), 64'hFFFF);
      end else begin
        item_t e;
        e = sb_q.pop_front();
        chk("sb_data", 64'(a_data), 64'(e.data));
        chk("sb_src", 64'(a_src), 64'(e.src));
      end
    end
  end

  // One cycle on instance A: drive, check ACK mid-cycle, push the expected load, advance.
  task automatic step(input logic [3:0] req, input logic rdy, input logic [3:0] exp_ack,
                      input string name);
    item_t e;
    a_req   = req;
    a_ready = rdy;
    #2;
    chk(name, 64'(a_ack), 64'(exp_ack));
    for (int i = 0; i < 4; i++) begin
      if (exp_ack[i]) begin
        e.data = a_x[i];
        e.src  = 2'(i);
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [2:0] req, input logic [2:0] exp_ack, input logic [1:0] exp_src,
                        input logic [15:0] exp_data, input string name);
    b_req   = req;
    b_ready = 1'b1;
    #2;
    chk({name, "_ack"}, 64'(b_ack), 64'(exp_ack));
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 64'(b_valid), 64'(1));
    chk({name, "_src"}, 64'(b_src), 64'(exp_src));
    chk({name, "_data"}, 64'(b_data), 64'(exp_data));
  endtask

  logic [3:0] rr_seq [8];

  initial begin
    a_x[0] = 32'hAAAA0000; a_x[1] = 32'hBBBB1111; a_x[2] = 32'hCCCC2222; a_x[3] = 32'hDDDD3333;
    b_x[0] = 16'h1110;     b_x[1] = 16'h2221;     b_x[2] = 16'h3332;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    rst = 1'b1;
    a_req = 4'b1111; a_ready = 1'b1;
    b_req = 3'b000;  b_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(a_valid), 64'(0));
    chk("rst_data", 64'(a_data), 64'(0));
    chk("rst_src", 64'(a_src), 64'(0));
    chk("rst_ack_forced0", 64'(a_ack), 64'(0));
    rst = 1'b0;

    // First load: single requester 0, one-cycle latency to OUT_VALID.
    step(4'b0001, 1'b1, 4'b0001, "first_ack");
    chk("first_valid", 64'(a_valid), 64'(1));
    chk("first_data", 64'(a_data), 64'hAAAA0000);
    chk("first_src", 64'(a_src), 64'(0));

    // ptr=1; granting index 3 wraps ptr back to 0.
    step(4'b1000, 1'b1, 4'b1000, "wrap_to_ptr0");

    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 1'b1, rr_seq[c], "rr_all_ack");
      chk("rr_valid", 64'(a_valid), 64'(1));
    end

    // Load index 2 (ptr->3), then stall with backpressure.
    step(4'b0100, 1'b1, 4'b0100, "load2_ack");
    for (int c = 0; c < 5; c++) begin
      step(4'b1011, 1'b0, 4'b0000, "stall_ack");
      chk("stall_valid", 64'(a_valid), 64'(1));
      chk("stall_data", 64'(a_data), 64'hCCCC2222);
      chk("stall_src", 64'(a_src), 64'(2));
    end
    step(4'b1011, 1'b1, 4'b1000, "unstall_ack_ptr3");

    // Drain with no requests: goes EMPTY, data held.
    step(4'b0000, 1'b1, 4'b0000, "drain_ack");
    chk("drain_valid", 64'(a_valid), 64'(0));
    chk("drain_data_hold", 64'(a_data), 64'hDDDD3333);
    chk("drain_src_hold", 64'(a_src), 64'(3));

    // Reset while FULL discards the held beat and suppresses ACK.
    step(4'b0100, 1'b0, 4'b0100, "pre_rst_load");
    rst = 1'b1;
    a_req = 4'b0100; a_ready = 1'b0;
    #2;
    chk("midrst_ack", 64'(a_ack), 64'(0));
    @(posedge clk);
    #1;
    sb_q.delete();
    rst = 1'b0;
    chk("midrst_valid", 64'(a_valid), 64'(0));
    chk("midrst_src", 64'(a_src), 64'(0));
    step(4'b0110, 1'b1, 4'b0010, "post_rst_ack");
    chk("post_rst_src", 64'(a_src), 64'(1));
    step(4'b0000, 1'b1, 4'b0000, "final_drain");
    chk("final_valid", 64'(a_valid), 64'(0));
    chk("sb_leftover", 64'(sb_q.size()), 64'(0));

    // N=3: get ptr to 2, then grant 2 (ptr wraps to 0), then 0, then round-robin from 1.
    step_b(3'b010, 3'b010, 2'd1, 16'h2221, "n3_load1");
    step_b(3'b100, 3'b100, 2'd2, 16'h3332, "n3_grant2");
    step_b(3'b001, 3'b001, 2'd0, 16'h1110, "n3_grant0");
    step_b(3'b111, 3'b010, 2'd1, 16'h2221, "n3_rr1");
    step_b(3'b111, 3'b100, 2'd2, 16'h3332, "n3_rr2");
    step_b(3'b111, 3'b001, 2'd0, 16'h1110, "n3_rr0");
    b_req = 3'b000;
    @(posedge clk);
    #1;
    chk("n3_drain_valid", 64'(b_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
